mac_accumulator: RTL
====================

# mac_accumulator

- Fetches up to 2^ADDR_W sample/coefficient pairs from a registered (1-cycle latency) buffer, multiplies each pair as signed 16×16, and sums the products into a 40-bit signed accumulator.
- Presents the finished sum on `acc` with a one-cycle `valid` strobe.
- Sits directly upstream of the output shifter/scaler, which takes the 40-bit `acc` and selects 16 bits.

## Interface
- `ADDR_W`, default 5: buffer address width. Maximum product count is 2^ADDR_W.
- `ACC_W`, default 40: accumulator and output width. Must be ≥ 32 + ADDR_W.

Ports:
- `ck` in 1: single clock. All logic updates on the rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `start` in 1: request a new accumulation. Sampled only in IDLE.
- `ntaps` in ADDR_W+1: number of products, 0..2^ADDR_W. Captured when `start` is accepted.
- `rd` out 1: buffer read enable.
- `addr` out ADDR_W: buffer read address, valid while `rd`=1.
- `sample` in 16: signed sample. Buffer data for the address presented in the previous cycle.
- `coef` in 16: signed coefficient. Same timing as `sample`.
- `busy` out 1: high from the cycle after an accepted start until the cycle `valid` is high (exclusive).
- `valid` out 1: one-cycle strobe. `acc` holds a new result.
- `acc` out ACC_W: signed result. Held until the next `valid`.

## Operation
States: IDLE, RUN, FLUSH1, FLUSH2.

IDLE:
- `start`=1 with `ntaps`≠0: capture `ntaps`, clear the internal sum, `addr`←0, `rd`←1, go to RUN.
- `start`=1 with `ntaps`=0: stay in IDLE; next cycle `valid`=1 and `acc`=0.

RUN:
- Each cycle `addr` increments by 1.
- When the address equal to `ntaps`−1 has been issued, `rd`←0 and go to FLUSH1.

FLUSH1 → FLUSH2 → IDLE, unconditional. These drain the data-capture and product pipeline registers.

Datapath pipeline, per read:
- Address in cycle c; `sample`/`coef` valid in c+1; product registered at the end of c+1; added to the sum at the end of c+2.
- Pipeline valid bits travel alongside the data. The adder only adds when its stage valid bit is set.

Arithmetic:
- Product is the 32-bit signed result of `sample`×`coef`, sign-extended to ACC_W.
- Sum wraps modulo 2^ACC_W; no saturation. Overflow is impossible within the parameter rule.

Output:
- On the transition FLUSH2→IDLE, `acc`←internal sum and `valid`←1 for exactly one cycle.
- `acc` is not disturbed during a subsequent run.

Start handling:
- `start` while busy is ignored and has no effect on the current run.
- `start` in the cycle `valid`=1 is accepted (state is IDLE). This allows back-to-back runs with no gap.

Reset (`rst_n`=0 at an edge):
- State→IDLE.
- `rd`=0, `addr`=0, `busy`=0, `valid`=0, `acc`=0.
- Internal sum and pipeline valid bits cleared.
- Reset mid-run aborts the run with no `valid` and no change to `acc` beyond the reset value.

## Timing
- Let cycle 0 be the cycle in which `start` is high in IDLE, with `ntaps`=N≥1.
- `rd`=1 in cycles 1..N, with `addr`=0..N−1.
- `busy`=1 in cycles 1..N+2.
- `valid`=1 and the final `acc` appear in cycle N+3.
- Throughput: one product per cycle; each run has a 3-cycle overhead.
- N=0: `valid`=1 in cycle 1, `busy` never asserts, `rd` never asserts.
- `acc` changes only in a `valid` cycle, or on reset.

## Test plan
- **Basic sum:** N=4, sample=1,2,3,4, coef=1 each, start in cycle 0 → `rd`/`addr` 0..3 in cycles 1–4, `valid` only in cycle 7, `acc`=10.
- **Full-scale positive:** N=32, all sample=coef=−32768 → `acc`=0x08_0000_0000, `valid` in cycle 35.
- **Full-scale negative:** N=32, sample=−32768, coef=32767 → `acc`=0xF8_0010_0000 (sign-extended negative), no wrap.
- **Zero taps and busy start:**
  - N=0 → `valid` in cycle 1 with `acc`=0; `rd` and `busy` stay 0.
  - Second `start` pulse in cycle 2 of an N=4 run → ignored; result and timing unchanged.
- **Back-to-back:** new start asserted in the `valid` cycle of the previous run → `acc` holds the first result until the second `valid`, N+3 cycles later; no cycle where `valid` is high twice.
- **Reset mid-run:** `rst_n`=0 for one edge in cycle 3 of an N=8 run → all outputs at reset values next cycle; no `valid` from the aborted run; a fresh N=2 run then gives the correct result.

Source files
------------

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - handshake and buffer bus for the multiply-accumulate engine
//
// Signals:
//   start, ntaps      : accumulation request and product count (controller -> engine)
//   rd, addr          : buffer read enable and address (engine -> buffer)
//   sample, coef      : signed buffer data, one cycle after addr (buffer -> engine)
//   busy, valid, acc  : run status, result strobe and signed result (engine -> controller)
// Modports: slave = engine side, master = controller/buffer side.
interface mac_accumulator_if #(
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 40
);
    logic                start;
    logic [ADDR_W:0]     ntaps;
    logic                rd;
    logic [ADDR_W-1:0]   addr;
    logic signed [15:0]  sample;
    logic signed [15:0]  coef;
    logic                busy;
    logic                valid;
    logic [ACC_W-1:0]    acc;

    modport slave (
        input  start, ntaps, sample, coef,
        output rd, addr, busy, valid, acc
    );

    modport master (
        output start, ntaps, sample, coef,
        input  rd, addr, busy, valid, acc
    );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - signed 16x16 multiply-accumulate over a registered sample/coef buffer
//
// Ports:
//   ck    : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mac_accumulator_if.slave (start/ntaps in, rd/addr to buffer, sample/coef back,
//           busy/valid/acc out)
// A run of N products issues addresses 0..N-1 in cycles 1..N, then drains the
// data and product stages in FLUSH1/FLUSH2; the result is strobed in cycle N+3.
module mac_accumulator #(
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 40
) (
    input  logic              ck,
    input  logic              rst_n,
    mac_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     ntaps_q;
    logic [ADDR_W:0]     ntaps_m1;
    logic                last_addr;
    logic                start_run;
    logic                start_zero;
    logic                d_vld;     // buffer data on sample/coef belongs to this run
    logic                p_vld;     // prod holds a product still to be summed
    logic signed [31:0]  prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    sum_next;
    logic [ACC_W-1:0]    acc;
    logic                valid;

    assign start_run  = (state == IDLE) && bus.start && (bus.ntaps != '0);
    assign start_zero = (state == IDLE) && bus.start && (bus.ntaps == '0);
    assign ntaps_m1   = ntaps_q - 1'b1;
    assign last_addr  = ({1'b0, addr} == ntaps_m1);
    assign prod_ext   = {{(ACC_W-32){prod[31]}}, prod};

    // The final product lands in the same edge that leaves FLUSH2, so the
    // result register takes the post-add value rather than the stored sum.
    assign sum_next   = p_vld ? (sum + prod_ext) : sum;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_run) state_d = RUN;
            RUN:     if (last_addr) state_d = FLUSH1;
            FLUSH1:  state_d = FLUSH2;
            FLUSH2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            addr    <= '0;
            ntaps_q <= '0;
            d_vld   <= 1'b0;
            p_vld   <= 1'b0;
            prod    <= '0;
            sum     <= '0;
            acc     <= '0;
            valid   <= 1'b0;
        end else begin
            d_vld <= (state == RUN);
            p_vld <= d_vld;
            valid <= (state == FLUSH2) || start_zero;
            if (d_vld) begin
                prod <= bus.sample * bus.coef;
            end
            if (start_run) begin
                ntaps_q <= bus.ntaps;
                addr    <= '0;
                sum     <= '0;
            end else begin
                if (state == RUN) begin
                    addr <= addr + 1'b1;
                end
                sum <= sum_next;
            end
            if (state == FLUSH2) begin
                acc <= sum_next;
            end else if (start_zero) begin
                acc <= '0;
            end
        end
    end

    assign bus.rd    = (state == RUN);
    assign bus.addr  = addr;
    assign bus.busy  = (state != IDLE);
    assign bus.valid = valid;
    assign bus.acc   = acc;
endmodule
